bcd_mod_display_counter: RTL and testbench



---
 rtl/bcd_mod_display_counter_pkg.sv | 26 ++
 rtl/bcd_mod_display_counter_digit.sv | 41 ++++
 rtl/bcd_mod_display_counter.sv | 128 ++++++++++++
 tb/tb_bcd_mod_display_counter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_mod_display_counter_pkg.sv
// Shared seven-segment definitions for the BCD display blocks: active-low {a,b,c,d,e,f,g}
// patterns, the blank code and the digit decoder.
package bcd_mod_display_counter_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b111_1111;

    localparam seg_t SEG_TABLE [10] = '{
        7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110, 7'b100_1100,
        7'b010_0100, 7'b010_0000, 7'b000_1111, 7'b000_0000, 7'b000_0100
    };

    // Non-decimal nibbles decode to blank.
    function automatic seg_t seg_decode(input logic [3:0] digit);
        seg_t seg;
        seg = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (digit == 4'(i)) begin
                seg = SEG_TABLE[i];
            end
        end
        return seg;
    endfunction

endpackage

// File: rtl/bcd_mod_display_counter_digit.sv
// One decade of the BCD counter: clear > load > increment, carry out when stepping past 9,
// and a flag comparing against this decade's digit of the terminal value.
module bcd_digit (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_in,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic [3:0] limit,
    output logic [3:0] digit,
    output logic       at_limit,
    output logic       carry_out
);

    logic [3:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clear) begin
            digit_d = 4'd0;
        end else if (load) begin
            digit_d = load_val;
        end else if (inc_in) begin
            digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit     = digit_q;
    assign at_limit  = (digit_q == limit);
    assign carry_out = inc_in & (digit_q == 4'd9);

endmodule

// File: rtl/bcd_mod_display_counter.sv
// Modulo-MOD BCD counter with prescaler, cascade carry, validated load and lap-hold display.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits above digit 0.
module bcd_mod_display_counter
    import bcd_mod_display_counter_pkg::*;
#(
    parameter int MOD      = 60,
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  step_in,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_bcd,
    input  logic                  hold,
    output logic [4*DIGITS-1:0]   value_bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  tc,
    output logic                  load_err
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]       p_q, p_d;
    logic [7*DIGITS-1:0] seg_q, seg_d;
    logic                load_err_q, load_err_d;

    logic                qual, inc, inc_eff, at_max, wrap, digit_clear;
    logic                load_digits_ok, load_ok;
    int                  load_value;
    logic [DIGITS-1:0]   at_limit;
    logic [DIGITS-1:0]   upper_zero;
    logic [DIGITS:0]     inc_chain;
    logic [4*DIGITS-1:0] count;

    assign qual    = enable & step_in;
    assign inc     = qual & (p_q == P_LAST);
    // Any clear or load request in the cycle swallows the increment.
    assign inc_eff = inc & ~clear & ~load;
    assign at_max  = &at_limit;
    assign wrap    = inc_eff & at_max;
    assign digit_clear  = clear | wrap;
    assign inc_chain[0] = inc_eff;

    always_comb begin
        load_digits_ok = 1'b1;
        load_value     = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (load_bcd[4*i +: 4] > 4'd9) begin
                load_digits_ok = 1'b0;
            end
            load_value = load_value * 10 + int'(load_bcd[4*i +: 4]);
        end
        load_ok = load & ~clear & load_digits_ok & (load_value < MOD);
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            localparam logic [3:0] LIMIT = 4'(((MOD - 1) / (10 ** gi)) % 10);
            bcd_digit u_digit (
                .clk       (clk),
                .reset     (reset),
                .inc_in    (inc_chain[gi]),
                .clear     (digit_clear),
                .load      (load_ok),
                .load_val  (load_bcd[4*gi +: 4]),
                .limit     (LIMIT),
                .digit     (count[4*gi +: 4]),
                .at_limit  (at_limit[gi]),
                .carry_out (inc_chain[gi+1])
            );
        end
    endgenerate

    wire unused_top_carry = inc_chain[DIGITS];

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;
    // upper_zero[i]: digit i and everything above it are zero.
    always_comb begin
        upper_zero = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run & (count[4*i +: 4] == 4'd0);
            upper_zero[i] = zero_run;
        end
    end
`else
    assign upper_zero = '0;
`endif

    always_comb begin
        p_d = p_q;
        if (clear || load_ok) begin
            p_d = '0;
        end else if (qual) begin
            p_d = (p_q == P_LAST) ? '0 : p_q + 1'b1;
        end
        load_err_d = load & ~clear & ~load_ok;
        seg_d = seg_q;
        if (!hold) begin
            for (int i = 0; i < DIGITS; i++) begin
                seg_d[7*i +: 7] = upper_zero[i] ? SEG_BLANK : seg_decode(count[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q        <= '0;
            seg_q      <= {DIGITS{SEG_TABLE[0]}};
            load_err_q <= 1'b0;
        end else begin
            p_q        <= p_d;
            seg_q      <= seg_d;
            load_err_q <= load_err_d;
        end
    end

    assign value_bcd = count;
    assign seg       = seg_q;
    assign tc        = wrap;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_mod_display_counter.sv
// Self-checking bench: integer reference model for the MOD=60/TICK_DIV=4 instance plus
// directed checks for cascade and the 3-digit display.
module tb_bcd_mod_display_counter;

    localparam int MODV = 60;
    localparam int TD   = 4;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                           S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                           S7 = 7'b0001111, S9 = 7'b0000100, SB = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        en = 0, stp = 0, clr = 0, ld = 0, hold = 0;
    logic [7:0]  ld_bcd = 8'h00;
    logic [7:0]  val;
    logic [13:0] seg;
    logic        tc, lerr;

    logic        cen = 0;
    logic [7:0]  a_val, b_val;
    logic [13:0] a_seg, b_seg;
    logic        a_tc, b_tc, a_err, b_err;

    logic        e3 = 0, ld3 = 0;
    logic [11:0] ld3_bcd = 12'h000;
    logic [11:0] val3;
    logic [20:0] seg3;
    logic        tc3, lerr3;

    int n_pass = 0, n_total = 0;

    bcd_mod_display_counter #(.MOD(60), .DIGITS(2), .TICK_DIV(4)) dut (
        .clk(clk), .reset(rst), .enable(en), .step_in(stp), .clear(clr), .load(ld),
        .load_bcd(ld_bcd), .hold(hold), .value_bcd(val), .seg(seg), .tc(tc), .load_err(lerr));

    bcd_mod_display_counter #(.MOD(60), .DIGITS(2), .TICK_DIV(1)) cas_a (
        .clk(clk), .reset(rst), .enable(cen), .step_in(1'b1), .clear(1'b0), .load(1'b0),
        .load_bcd(8'h00), .hold(1'b0), .value_bcd(a_val), .seg(a_seg), .tc(a_tc), .load_err(a_err));

    bcd_mod_display_counter #(.MOD(24), .DIGITS(2), .TICK_DIV(1)) cas_b (
        .clk(clk), .reset(rst), .enable(cen), .step_in(a_tc), .clear(1'b0), .load(1'b0),
        .load_bcd(8'h00), .hold(1'b0), .value_bcd(b_val), .seg(b_seg), .tc(b_tc), .load_err(b_err));

    bcd_mod_display_counter #(.MOD(100), .DIGITS(3), .TICK_DIV(1)) dut3 (
        .clk(clk), .reset(rst), .enable(e3), .step_in(1'b1), .clear(1'b0), .load(ld3),
        .load_bcd(ld3_bcd), .hold(1'b0), .value_bcd(val3), .seg(seg3), .tc(tc3), .load_err(lerr3));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (spec-level integer arithmetic) ----------------
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return S0;  1: return S1;  2: return S2;  3: return S3;  4: return S4;
            5: return S5;  6: return 7'b0100000;  7: return S7;  8: return 7'b0000000;
            9: return S9;  default: return SB;
        endcase
    endfunction

    function automatic logic [27:0] disp(input int cnt, input int nd);
        logic [27:0] r;
        int pw;
        r = '1;
        pw = 1;
        for (int i = 0; i < nd; i++) begin
            r[7*i +: 7] = seg_of((cnt / pw) % 10);
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && cnt < pw) r[7*i +: 7] = SB;
`endif
            pw = pw * 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic bit load_valid(input logic [7:0] b, output int v);
        v = int'(b[7:4]) * 10 + int'(b[3:0]);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (v < MODV);
    endfunction

    int          m_cnt = 0, m_p = 0;
    logic [13:0] m_seg = {S0, S0};
    logic        m_err = 1'b0;

    always @(posedge clk or posedge rst) begin
        logic [27:0] d;
        int lv;
        bit ok;
        if (rst) begin
            m_cnt <= 0; m_p <= 0; m_seg <= {S0, S0}; m_err <= 1'b0;
        end else begin
            ok = load_valid(ld_bcd, lv);
            d  = disp(m_cnt, 2);
            m_err <= ld && !clr && !ok;
            if (!hold) m_seg <= d[13:0];
            if (clr) begin
                m_cnt <= 0; m_p <= 0;
            end else if (ld && ok) begin
                m_cnt <= lv; m_p <= 0;
            end else begin
                if (en && stp) m_p <= (m_p + 1) % TD;
                if (en && stp && m_p == TD - 1 && !ld) m_cnt <= (m_cnt + 1) % MODV;
            end
        end
    end

    always @(negedge clk) begin
        check("model_value", val, to_bcd(m_cnt) & 16'h00FF);
        check("model_seg", seg, m_seg);
        check("model_load_err", lerr, m_err);
        check("model_tc", tc, en && stp && m_p == TD - 1 && m_cnt == MODV - 1 && !clr && !ld);
    end

    int b_tc_cnt = 0;
    bit casc_run = 0;
    always @(negedge clk) if (casc_run && b_tc) b_tc_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tick(3);
        check("reset_value", val, 8'h00);
        check("reset_seg", seg, {S0, S0});
        check("reset_load_err", lerr, 1'b0);

        // free-running count from reset
        rst = 0; en = 1; stp = 1;
        tick(4);   check("cycle4_value", val, 8'h01);
        tick(232); check("cycle236_value", val, 8'h59);
        tick(1);   check("cycle237_seg", seg, {S5, S9});
        tick(2);   check("cycle239_tc", tc, 1'b1);
        tick(1);   check("cycle240_value", val, 8'h00);
                   check("cycle240_tc", tc, 1'b0);

        // load: valid, then two rejected values
        tick(10);
        ld = 1; ld_bcd = 8'h45; tick(1); ld = 0;
        check("load45_value", val, 8'h45);
        tick(3); check("load45_p_reset", val, 8'h45);
        tick(1); check("load45_first_inc", val, 8'h46);
        ld = 1; ld_bcd = 8'h60; tick(1); ld = 0;
        check("load60_value", val, 8'h46);
        check("load60_err", lerr, 1'b1);
        ld = 1; ld_bcd = 8'h3A; tick(1); ld = 0;
        check("load3A_value", val, 8'h46);
        check("load3A_err", lerr, 1'b1);
        tick(1); check("load_err_clears", lerr, 1'b0);

        // lap hold
        ld = 1; ld_bcd = 8'h12; tick(1); ld = 0;
        tick(1); hold = 1;
        tick(79);
        check("hold_value", val, 8'h32);
        check("hold_seg", seg, {S1, S2});
        hold = 0; tick(1);
        check("release_seg", seg, {S3, S2});

        // clear colliding with wrap increment
        ld = 1; ld_bcd = 8'h59; tick(1); ld = 0;
        tick(3); check("pre_wrap_tc", tc, 1'b1);
        clr = 1; #1 check("clear_tc", tc, 1'b0);
        tick(1); clr = 0;
        check("clear_value", val, 8'h00);

        // async reset mid-prescale
        ld = 1; ld_bcd = 8'h37; tick(1); ld = 0;
        tick(2);
        ld = 1; ld_bcd = 8'h99; tick(1); ld = 0;
        #2 rst = 1;
        #1 check("async_value", val, 8'h00);
        check("async_seg", seg, {S0, S0});
        check("async_load_err", lerr, 1'b0);
        check("async_tc", tc, 1'b0);
        tick(2); rst = 0; en = 0;

        // cascade 60 x 24
        cen = 1; casc_run = 1;
        tick(60);
        check("cascade_b_at60", b_val, 8'h01);
        check("cascade_a_at60", a_val, 8'h00);
        tick(1380);
        cen = 0; casc_run = 0;
        check("cascade_a_1440", a_val, 8'h00);
        check("cascade_b_1440", b_val, 8'h00);
        check("cascade_b_tc_pulses", b_tc_cnt, 1);

        // three-digit display
`ifdef LEADING_ZERO_BLANK_EN
        check("d3_zero_seg", seg3, {SB, SB, S0});
`else
        check("d3_zero_seg", seg3, {S0, S0, S0});
`endif
        e3 = 1; tick(7); e3 = 0; tick(1);
        check("d3_value7", val3, 12'h007);
`ifdef LEADING_ZERO_BLANK_EN
        check("d3_seven_seg", seg3, {SB, SB, S7});
`else
        check("d3_seven_seg", seg3, {S0, S0, S7});
`endif
        ld3 = 1; ld3_bcd = 12'h042; tick(1); ld3 = 0; tick(1);
        check("d3_value42", val3, 12'h042);
`ifdef LEADING_ZERO_BLANK_EN
        check("d3_42_seg", seg3, {SB, S4, S2});
`else
        check("d3_42_seg", seg3, {S0, S4, S2});
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
